// File: rtl/demosaic_mul_arb_pkg.sv
// demosaic_mul_arb_pkg: default operand/product widths and FSM state encoding
// shared by the demosaic multiplier arbiter and its grant logic.
package demosaic_mul_arb_pkg;

   localparam int unsigned DMA_A_WIDTH = 18;
   localparam int unsigned DMA_B_WIDTH = 8;
   localparam int unsigned DMA_P_WIDTH = 25;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

endpackage

// File: rtl/demosaic_mul_arb_rr.sv
// demosaic_mul_arb_rr: one-hot grant selection for the shared multiplier.
// With DEMOSAIC_MUL_ARB_ROUND_ROBIN_EN defined the search starts at ptr_i and
// ptr_next_o is the index after the winner; otherwise lowest index wins and
// the pointer ports do not exist.
module demosaic_mul_arb_rr
   import demosaic_mul_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req_i,
`ifdef DEMOSAIC_MUL_ARB_ROUND_ROBIN_EN
   input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] ptr_i,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] ptr_next_o,
`endif
   output logic [NUM_REQ-1:0] grant_o
);

`ifdef DEMOSAIC_MUL_ARB_ROUND_ROBIN_EN
   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // First requesting index at or after the pointer, wrapping around.
   always_comb begin
      logic [PTR_W-1:0] idx;
      grant_o    = '0;
      ptr_next_o = ptr_i;
      idx        = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = PTR_W'((32'(ptr_i) + off) % NUM_REQ);
         if (req_i[idx] && (grant_o == '0)) begin
            grant_o[idx] = 1'b1;
            ptr_next_o   = PTR_W'((32'(idx) + 1) % NUM_REQ);
         end
      end
   end
`else
   // Fixed priority: lowest requesting index wins.
   always_comb begin
      grant_o = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req_i[i] && (grant_o == '0)) begin
            grant_o[i] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/demosaic_mul_arbiter.sv
// demosaic_mul_arbiter: shares one unsigned A x B multiplier among NUM_REQ
// requesters. One grant per cycle in RUN, operands registered in stage 1, the
// multiply sits between stage 1 and stage 2, results return one-hot after
// 1+MUL_STAGES cycles. Build option: DEMOSAIC_MUL_ARB_ROUND_ROBIN_EN selects
// round-robin arbitration (default build is fixed priority).
module demosaic_mul_arbiter
   import demosaic_mul_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned A_WIDTH    = DMA_A_WIDTH,
   parameter int unsigned B_WIDTH    = DMA_B_WIDTH,
   parameter int unsigned P_WIDTH    = DMA_P_WIDTH,
   parameter int unsigned MUL_STAGES = 2
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst,
   input  logic                         cfg_enable,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [P_WIDTH-1:0]           rsp_p,
   output logic                         idle
);

   arb_state_e                 state_q, state_d;
   logic                       grant_en;
   logic [NUM_REQ-1:0]         req_masked;
   logic [NUM_REQ-1:0]         grant;
   logic [A_WIDTH-1:0]         mux_a, s1_a_q;
   logic [B_WIDTH-1:0]         mux_b, s1_b_q;
   logic                       s1_v_q;
   logic [NUM_REQ-1:0]         s1_id_q;
   logic [A_WIDTH+B_WIDTH-1:0] prod_full;
   logic [P_WIDTH-1:0]         prod;
   logic                       tail_v;
   logic [NUM_REQ-1:0]         tail_id;
   logic [P_WIDTH-1:0]         tail_p;
   logic                       deep_busy, pipe_busy;
   logic [NUM_REQ-1:0]         rsp_valid_q;
   logic [P_WIDTH-1:0]         rsp_p_q;

   assign grant_en   = (state_q == ST_RUN) && cfg_enable;
   assign req_masked = req_valid & {NUM_REQ{grant_en}};
   assign req_ready  = grant;

`ifdef DEMOSAIC_MUL_ARB_ROUND_ROBIN_EN
   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_next;

   demosaic_mul_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i      (req_masked),
      .ptr_i      (ptr_q),
      .ptr_next_o (ptr_next),
      .grant_o    (grant)
   );

   // Pointer advances only when a grant is made.
   always_comb begin
      ptr_d = (grant != '0) ? ptr_next : ptr_q;
   end

   // Round-robin pointer register.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`else
   demosaic_mul_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i   (req_masked),
      .grant_o (grant)
   );
`endif

   // Next-state: enable starts granting, disable drains until stages empty.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cfg_enable) state_d = ST_RUN;
         ST_RUN:   if (!cfg_enable) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (cfg_enable)      state_d = ST_RUN;
            else if (!pipe_busy) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Operand mux driven by the one-hot grant.
   always_comb begin
      mux_a = '0;
      mux_b = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            mux_a = req_a[i*A_WIDTH +: A_WIDTH];
            mux_b = req_b[i*B_WIDTH +: B_WIDTH];
         end
      end
   end

   // Stage 1: granted operands and requester id.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         s1_v_q  <= 1'b0;
         s1_id_q <= '0;
         s1_a_q  <= '0;
         s1_b_q  <= '0;
      end else begin
         s1_v_q  <= |grant;
         s1_id_q <= grant;
         s1_a_q  <= mux_a;
         s1_b_q  <= mux_b;
      end
   end

   assign prod_full = s1_a_q * s1_b_q;
   assign prod      = P_WIDTH'(prod_full);

   // With a single stage the product feeds the output register directly.
   if (MUL_STAGES == 1) begin : g_one
      assign tail_v    = s1_v_q;
      assign tail_id   = s1_id_q;
      assign tail_p    = prod;
      assign deep_busy = 1'b0;
   end else begin : g_deep
      logic               pv_q  [MUL_STAGES-1];
      logic [NUM_REQ-1:0] pid_q [MUL_STAGES-1];
      logic [P_WIDTH-1:0] pp_q  [MUL_STAGES-1];

      // Stages 2..MUL_STAGES: product shift register.
      always_ff @(posedge ap_clk) begin
         if (ap_rst) begin
            for (int unsigned k = 0; k < MUL_STAGES-1; k++) begin
               pv_q[k]  <= 1'b0;
               pid_q[k] <= '0;
               pp_q[k]  <= '0;
            end
         end else begin
            pv_q[0]  <= s1_v_q;
            pid_q[0] <= s1_id_q;
            pp_q[0]  <= prod;
            for (int unsigned k = 1; k < MUL_STAGES-1; k++) begin
               pv_q[k]  <= pv_q[k-1];
               pid_q[k] <= pid_q[k-1];
               pp_q[k]  <= pp_q[k-1];
            end
         end
      end

      // Any product stage still holding an operation.
      always_comb begin
         deep_busy = 1'b0;
         for (int unsigned k = 0; k < MUL_STAGES-1; k++) begin
            deep_busy = deep_busy | pv_q[k];
         end
      end

      assign tail_v  = pv_q[MUL_STAGES-2];
      assign tail_id = pid_q[MUL_STAGES-2];
      assign tail_p  = pp_q[MUL_STAGES-2];
   end

   assign pipe_busy = s1_v_q | deep_busy;
   assign idle      = (state_q == ST_IDLE) && !pipe_busy;

   // Response decode: single-cycle one-hot strobe, product held between strobes.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         rsp_valid_q <= '0;
         rsp_p_q     <= '0;
      end else begin
         rsp_valid_q <= tail_v ? tail_id : '0;
         if (tail_v) rsp_p_q <= tail_p;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_p     = rsp_p_q;

endmodule

// File: tb/tb_demosaic_mul_arbiter.sv
// tb_demosaic_mul_arbiter: directed stimulus with a transaction-level model
// checked every cycle, plus literal expectations at key points.
module tb_demosaic_mul_arbiter;

   localparam int LAT = 3;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        cfg_enable = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [71:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [3:0]  rsp_valid;
   logic [24:0] rsp_p;
   logic        idle;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 ap_clk = ~ap_clk;

   demosaic_mul_arbiter #(
      .NUM_REQ(4), .A_WIDTH(18), .B_WIDTH(8), .P_WIDTH(25), .MUL_STAGES(2)
   ) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .cfg_enable(cfg_enable),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_p(rsp_p), .idle(idle)
   );

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
      end
   endtask

   // Requesters: each holds its head operation until it is transferred.
   logic [25:0] opq [4][$];
   logic [3:0]  xfer = '0;

   always @(posedge ap_clk) begin
      #2;
      for (int i = 0; i < 4; i++) begin
         if (xfer[i] && opq[i].size() > 0) void'(opq[i].pop_front());
         req_valid[i] = (opq[i].size() > 0);
         if (opq[i].size() > 0) {req_a[i*18 +: 18], req_b[i*8 +: 8]} = opq[i][0];
      end
   end

   // Behavioural model: arbitration rule, queue of in-flight results by due cycle.
   typedef struct { int due; logic [3:0] id; logic [24:0] p; } exp_t;
   typedef enum int { M_IDLE, M_RUN, M_DRAIN } mmode_e;

   exp_t        mq[$];
   mmode_e      mmode = M_IDLE;
   int          mptr = 0;
   logic [24:0] mlast = '0;
   bit          mvalid = 1'b0;

   function automatic logic [3:0] pick(logic [3:0] v, int p);
      logic [3:0] g;
      g = '0;
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (p + k) % 4;
         if (v[i] && g == '0) g[i] = 1'b1;
      end
      return g;
   endfunction

   function automatic logic [24:0] mul25(logic [17:0] a, logic [7:0] b);
      longint unsigned x;
      x = 64'(a) * 64'(b);
      return x[24:0];
   endfunction

   always @(negedge ap_clk) begin
      logic [3:0]  ev, eg;
      logic [24:0] ep;
      bit          busy;
      int          gi;
      cyc++;
      xfer = req_valid & req_ready;
      ev = '0; eg = '0; ep = mlast; busy = 1'b0;
      if (mvalid) begin
         if (mq.size() > 0 && mq[0].due == cyc) begin
            ev = mq[0].id;
            ep = mq[0].p;
            mlast = ep;
            void'(mq.pop_front());
         end
         eg = (mmode == M_RUN && cfg_enable) ? pick(req_valid, mptr) : 4'b0;
         busy = (mq.size() > 0);
         chk("m_req_ready", 32'(req_ready), 32'(eg));
         chk("m_rsp_valid", 32'(rsp_valid), 32'(ev));
         chk("m_rsp_p", 32'(rsp_p), 32'(ep));
         chk("m_idle", 32'(idle), 32'((mmode == M_IDLE) && !busy));
      end
      if (ap_rst) begin
         mq.delete();
         mptr = 0;
         mlast = '0;
         mmode = M_IDLE;
         mvalid = 1'b1;
      end else if (mvalid) begin
         if (eg != '0) begin
            gi = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) gi = i;
            mq.push_back('{due: cyc + LAT, id: eg,
                           p: mul25(req_a[gi*18 +: 18], req_b[gi*8 +: 8])});
`ifdef DEMOSAIC_MUL_ARB_ROUND_ROBIN_EN
            mptr = (gi + 1) % 4;
`endif
         end
         case (mmode)
            M_IDLE:  if (cfg_enable) mmode = M_RUN;
            M_RUN:   if (!cfg_enable) mmode = M_DRAIN;
            default: begin
               if (cfg_enable) mmode = M_RUN;
               else if (!busy) mmode = M_IDLE;
            end
         endcase
      end
   end

   task automatic sync();
      @(posedge ap_clk);
      #1;
   endtask

   initial begin
      int pending;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_p", 32'(rsp_p), 32'h0);
      chk("rst_idle", 32'(idle), 32'h1);
      sync();
      ap_rst = 1'b0;

      // Single op with truncated product.
      cfg_enable = 1'b1;
      opq[0].push_back({18'h3FFFF, 8'hFF});
      @(posedge ap_clk); @(negedge ap_clk);
      chk("t1_grant", 32'(req_ready), 32'h1);
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_p", 32'(rsp_p), 32'h1FBFF01);
      repeat (3) sync();

      // All four requesters busy: fairness / priority order.
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 2; k++)
            opq[i].push_back({18'(i * 18'h1111 + k * 18'h20001), 8'(i * 8'h21 + k * 8'h0F + 1)});
      repeat (16) sync();

      // req0 continuous alongside req2.
      for (int k = 0; k < 4; k++) opq[0].push_back({18'(18'h00101 * (k + 1)), 8'(8'h11 * (k + 1))});
      opq[2].push_back({18'h2FEDC, 8'hC3});
      repeat (14) sync();

      // Zero operand, unit product, stalled requester with its own operands.
      opq[0].push_back({18'h12345, 8'h00});
      opq[0].push_back({18'h00007, 8'h03});
      opq[0].push_back({18'h00100, 8'h10});
      opq[1].push_back({18'h00001, 8'h01});
      opq[3].push_back({18'h2ABCD, 8'h5A});
      repeat (14) sync();

      // Drain: grants at t and t+1, enable dropped at t+2.
      opq[0].push_back({18'h00155, 8'h33});
      opq[1].push_back({18'h002AA, 8'h44});
      @(posedge ap_clk); @(posedge ap_clk); #1;
      cfg_enable = 1'b0;
      @(negedge ap_clk);
      chk("drain_no_grant", 32'(req_ready), 32'h0);
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("drain_t4_idle", 32'(idle), 32'h0);
      @(posedge ap_clk); @(negedge ap_clk);
      chk("drain_t5_idle", 32'(idle), 32'h1);

      // Reset one cycle after a grant discards the operation.
      sync();
      cfg_enable = 1'b1;
      repeat (2) sync();
      opq[2].push_back({18'h3FFFF, 8'h80});
      @(posedge ap_clk); #1;
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("rst_mid_idle", 32'(idle), 32'h1);
      chk("rst_mid_ready", 32'(req_ready), 32'h0);
      @(posedge ap_clk); @(negedge ap_clk);
      chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_mid_rsp_p", 32'(rsp_p), 32'h0);
      sync();
      opq[1].push_back({18'h00003, 8'h05});
      opq[3].push_back({18'h00007, 8'h09});
      @(negedge ap_clk);
      chk("rst_ptr_grant", 32'(req_ready), 32'h2);
      repeat (8) sync();

      cfg_enable = 1'b0;
      repeat (8) sync();
      @(negedge ap_clk);
      chk("end_idle", 32'(idle), 32'h1);
      pending = mq.size();
      for (int i = 0; i < 4; i++) pending += opq[i].size();
      chk("end_drained", 32'(pending), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
